// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory request/response path, the redirect strobe
// and the instruction-queue output port of the fetch unit.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    // imem: a request is taken in every cycle imem_req_o=1 (no grant), and exactly one
    // imem_rvalid_i answers it one or more cycles later. iq: the head is popped in any
    // cycle with iq_valid_o && iq_ready_i. redirect_i overrides both in its cycle.
    logic             imem_req_o;
    logic [WIDTH-1:0] imem_addr_o;
    logic             imem_rvalid_i;
    logic [WIDTH-1:0] imem_rdata_i;
    logic             redirect_i;
    logic [WIDTH-1:0] redirect_addr_i;
    logic             iq_valid_o;
    logic [WIDTH-1:0] iq_instr_o;
    logic [WIDTH-1:0] iq_pc_o;
    logic             iq_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, iq_valid_o, iq_instr_o, iq_pc_o,
        input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_addr_i, iq_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, iq_valid_o, iq_instr_o, iq_pc_o,
        output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_addr_i, iq_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps one imem read in flight
// and buffers returned words, tagged with their PC, in an in-order queue.
module fetch_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0040_0000),
    parameter int               DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output logic [1:0]   dbg_state_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] fetch_pc_q;
    logic [WIDTH-1:0] req_pc_q;
    logic [WIDTH-1:0] redirect_pc;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    logic full;
    logic empty;
    logic issue;
    logic push;
    logic pop;

    assign redirect_pc = bus.redirect_addr_i & ~WIDTH'(3);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);

    // Request is combinational from state; gating with rst_n keeps it low while in reset.
    assign issue = rst_n && (state_q == ISSUE) && !full && !bus.redirect_i;
    assign push  = (state_q == WAIT) && bus.imem_rvalid_i && !bus.redirect_i;
    assign pop   = !empty && bus.iq_ready_i && !bus.redirect_i;

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = issue ? fetch_pc_q : '0;
    assign bus.iq_valid_o  = !empty;
    assign bus.iq_instr_o  = empty ? '0 : instr_mem_q[rd_ptr_q];
    assign bus.iq_pc_o     = empty ? '0 : pc_mem_q[rd_ptr_q];
    assign dbg_state_o     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_ADDR;
            req_pc_q   <= '0;
        end else begin
            case (state_q)
                ISSUE: begin
                    if (bus.redirect_i) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (!full) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + WIDTH'(4);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.redirect_i) begin
                        fetch_pc_q <= redirect_pc;
                        state_q    <= bus.imem_rvalid_i ? ISSUE : DROP;
                    end else if (bus.imem_rvalid_i) begin
                        state_q <= ISSUE;
                    end
                end
                DROP: begin
                    // The squashed response still has to be absorbed before issuing again.
                    if (bus.redirect_i) fetch_pc_q <= redirect_pc;
                    if (bus.imem_rvalid_i) state_q <= ISSUE;
                end
                default: state_q <= ISSUE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a transaction-level queue model.
module tb_fetch_unit;
    localparam int          W      = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic        Y      = 1'b1;
    localparam logic        N      = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    logic [1:0] s_reset;

    fetch_unit_if #(.WIDTH(W)) bus ();

    fetch_unit #(.WIDTH(W), .RESET_ADDR(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding-request flags plus a queue of expected {pc, instr}.
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_pc, m_req_pc;
    logic           m_busy, m_drop;
    logic [W-1:0]   req_log[$];

    // Memory responder state.
    logic mem_pend;
    int   mem_cnt;
    int   lat_max;

    typedef struct {
        logic         redir;
        logic [W-1:0] raddr;
        logic         ready;
        logic         rv;
        logic [W-1:0] rdata;
        logic         e_req;
        logic [W-1:0] e_addr;
        logic         e_valid;
        logic [W-1:0] e_pc;
        logic [W-1:0] e_instr;
    } vec_t;

    vec_t vt[21];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_rvalid_i   = 1'b0;
        bus.imem_rdata_i    = '0;
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = '0;
        bus.iq_ready_i      = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req",   W'(bus.imem_req_o), '0);
        check("rst_addr",  bus.imem_addr_o, '0);
        check("rst_valid", W'(bus.iq_valid_o), '0);
        check("rst_instr", bus.iq_instr_o, '0);
        check("rst_pc",    bus.iq_pc_o, '0);
        s_reset = dbg_state;
        exp_q.delete();
        req_log.delete();
        m_pc = RST_PC; m_req_pc = '0; m_busy = 1'b0; m_drop = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0;
        rst_n = 1'b1;
    endtask

    // One clock cycle with the memory responder and the model in the loop.
    task automatic cyc(input logic redir, input logic [W-1:0] raddr, input logic ready);
        logic         rv;
        logic         exp_req;
        logic [W-1:0] exp_addr;
        rv = mem_pend && (mem_cnt == 0);
        bus.redirect_i      = redir;
        bus.redirect_addr_i = raddr;
        bus.iq_ready_i      = ready;
        bus.imem_rvalid_i   = rv;
        bus.imem_rdata_i    = $urandom;
        @(negedge clk);
        exp_req  = !m_busy && (exp_q.size() < DEPTH) && !redir;
        exp_addr = exp_req ? m_pc : '0;
        check("req",   W'(bus.imem_req_o), W'(exp_req));
        check("addr",  bus.imem_addr_o, exp_addr);
        check("valid", W'(bus.iq_valid_o), W'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("head_pc",    bus.iq_pc_o, exp_q[0][2*W-1:W]);
            check("head_instr", bus.iq_instr_o, exp_q[0][W-1:0]);
        end
        if (bus.imem_req_o) req_log.push_back(bus.imem_addr_o);
        if (redir) begin
            exp_q.delete();
            m_pc = raddr & ~32'h3;
            if (m_busy) begin
                if (rv) begin m_busy = 1'b0; m_drop = 1'b0; end
                else m_drop = 1'b1;
            end
        end else begin
            if (ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (m_busy && rv) begin
                if (!m_drop) exp_q.push_back({m_req_pc, bus.imem_rdata_i});
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (exp_req) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_busy   = 1'b1;
            end
        end
        if (rv) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (bus.imem_req_o && !mem_pend) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(lat_max - 1, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        bus.redirect_i      = vt[i].redir;
        bus.redirect_addr_i = vt[i].raddr;
        bus.iq_ready_i      = vt[i].ready;
        bus.imem_rvalid_i   = vt[i].rv;
        bus.imem_rdata_i    = vt[i].rdata;
        @(negedge clk);
        check($sformatf("v%0d_req", i),   W'(bus.imem_req_o), W'(vt[i].e_req));
        check($sformatf("v%0d_addr", i),  bus.imem_addr_o, vt[i].e_addr);
        check($sformatf("v%0d_valid", i), W'(bus.iq_valid_o), W'(vt[i].e_valid));
        if (vt[i].e_valid) begin
            check($sformatf("v%0d_pc", i),    bus.iq_pc_o, vt[i].e_pc);
            check($sformatf("v%0d_instr", i), bus.iq_instr_o, vt[i].e_instr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        lat_max = 1;
        //         redir raddr          rdy rv rdata          req addr           vld pc             instr
        vt[0]  = '{N, 32'h0,          Y, N, 32'h0,          Y, 32'h0040_0000, N, 32'h0,          32'h0};
        vt[1]  = '{N, 32'h0,          Y, Y, 32'hA000_0001,  N, 32'h0,         N, 32'h0,          32'h0};
        vt[2]  = '{N, 32'h0,          Y, N, 32'h0,          Y, 32'h0040_0004, Y, 32'h0040_0000, 32'hA000_0001};
        vt[3]  = '{N, 32'h0,          Y, Y, 32'hA000_0002,  N, 32'h0,         N, 32'h0,          32'h0};
        vt[4]  = '{N, 32'h0,          Y, N, 32'h0,          Y, 32'h0040_0008, Y, 32'h0040_0004, 32'hA000_0002};
        vt[5]  = '{Y, 32'h0040_0103,  Y, N, 32'h0,          N, 32'h0,         N, 32'h0,          32'h0};
        vt[6]  = '{N, 32'h0,          Y, N, 32'h0,          N, 32'h0,         N, 32'h0,          32'h0};
        vt[7]  = '{N, 32'h0,          Y, Y, 32'hA000_0003,  N, 32'h0,         N, 32'h0,          32'h0};
        vt[8]  = '{N, 32'h0,          Y, N, 32'h0,          Y, 32'h0040_0100, N, 32'h0,          32'h0};
        vt[9]  = '{Y, 32'h0050_0000,  Y, Y, 32'hA000_0004,  N, 32'h0,         N, 32'h0,          32'h0};
        vt[10] = '{N, 32'h0,          N, N, 32'h0,          Y, 32'h0050_0000, N, 32'h0,          32'h0};
        vt[11] = '{N, 32'h0,          N, Y, 32'hA000_0005,  N, 32'h0,         N, 32'h0,          32'h0};
        vt[12] = '{N, 32'h0,          N, N, 32'h0,          Y, 32'h0050_0004, Y, 32'h0050_0000, 32'hA000_0005};
        vt[13] = '{N, 32'h0,          N, Y, 32'hA000_0006,  N, 32'h0,         Y, 32'h0050_0000, 32'hA000_0005};
        vt[14] = '{N, 32'h0,          Y, N, 32'h0,          Y, 32'h0050_0008, Y, 32'h0050_0000, 32'hA000_0005};
        vt[15] = '{N, 32'h0,          N, Y, 32'hA000_0007,  N, 32'h0,         Y, 32'h0050_0004, 32'hA000_0006};
        vt[16] = '{Y, 32'hFFFF_FFFC,  Y, N, 32'h0,          N, 32'h0,         Y, 32'h0050_0004, 32'hA000_0006};
        vt[17] = '{N, 32'h0,          N, N, 32'h0,          Y, 32'hFFFF_FFFC, N, 32'h0,          32'h0};
        vt[18] = '{N, 32'h0,          N, Y, 32'hA000_0008,  N, 32'h0,         N, 32'h0,          32'h0};
        vt[19] = '{N, 32'h0,          N, N, 32'h0,          Y, 32'h0000_0000, Y, 32'hFFFF_FFFC, 32'hA000_0008};
        vt[20] = '{N, 32'h0,          N, N, 32'h0,          N, 32'h0,         Y, 32'hFFFF_FFFC, 32'hA000_0008};

        do_reset();
        for (int i = 0; i < 21; i++) apply_vec(i);

        // Fill with the consumer stalled: exactly DEPTH requests, then one pop frees a slot.
        do_reset();
        lat_max = 1;
        for (int i = 0; i < 12; i++) cyc(N, '0, N);
        check("fill_nreq", W'(req_log.size()), W'(DEPTH));
        for (int i = 0; i < DEPTH && i < req_log.size(); i++)
            check($sformatf("fill_addr%0d", i), req_log[i], RST_PC + W'(4 * i));
        check("fill_valid", W'(bus.iq_valid_o), W'(1));
        cyc(N, '0, Y);
        for (int i = 0; i < 3; i++) cyc(N, '0, N);
        check("refill_nreq", W'(req_log.size()), W'(DEPTH + 1));
        if (req_log.size() > DEPTH) check("refill_addr", req_log[DEPTH], 32'h0040_0010);

        // Reset asserted in WAIT with two entries queued.
        do_reset();
        lat_max = 1;
        for (int i = 0; i < 5; i++) cyc(N, '0, N);
        check("mid_state_busy", W'(dbg_state != s_reset), W'(1));
        check("mid_valid_pre", W'(bus.iq_valid_o), W'(1));
        rst_n = 1'b0;
        #1;
        check("mid_req",   W'(bus.imem_req_o), '0);
        check("mid_addr",  bus.imem_addr_o, '0);
        check("mid_valid", W'(bus.iq_valid_o), '0);
        check("mid_pc",    bus.iq_pc_o, '0);
        check("mid_instr", bus.iq_instr_o, '0);
        do_reset();
        cyc(N, '0, Y);
        check("post_rst_addr", req_log.size() > 0 ? req_log[0] : '1, RST_PC);

        // Randomized traffic: variable latency, stalls, redirects (some near the wrap point).
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic         redir;
            logic [W-1:0] raddr;
            lat_max = $urandom_range(4, 1);
            redir   = ($urandom_range(15, 0) == 0);
            raddr   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                  : 32'($urandom);
            cyc(redir, raddr, ($urandom_range(3, 0) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
